// File: rtl/chi_reset_pkg.sv
// Shared types and helpers for the CHI multi-node reset sequencer.
package chi_reset_pkg;

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    RUN,
    WARM
  } chi_rst_state_e;

  // Release index width; covers up to 255 channels plus the "all released" value.
  localparam int CHI_RST_IDX_W = 8;
  typedef logic [CHI_RST_IDX_W-1:0] chi_rst_idx_t;

  function automatic int chi_rst_nch(input int num_rn, input int num_sn);
    return num_rn + num_sn;
  endfunction

endpackage

// File: rtl/chi_reset_cnt.sv
// Loadable down-counter that parks at zero; shared by hold, stagger and warm phases.
module chi_reset_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] value_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= load_val;
    end else if (value_q != '0) begin
      value_q <= value_q - CNT_W'(1);
    end
  end

  assign value = value_q;
  assign zero  = (value_q == '0);

endmodule

// File: rtl/chi_reset_seq.sv
// Multi-node reset sequencer: cold hold, staggered release, per-channel warm resets.
//   HOLD    | all resets asserted, counting the hold period
//   RELEASE | deasserting channels one by one, STAGGER apart
//   RUN     | fabric out of reset, accepting warm requests
//   WARM    | one channel held in reset for the requested length
module chi_reset_seq
  import chi_reset_pkg::*;
#(
  parameter int NUM_RN      = 4,
  parameter int NUM_SN      = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 2,
  parameter int CNT_W       = 16,
  localparam int NCH        = chi_rst_nch(NUM_RN, NUM_SN),
  localparam int CH_W       = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cold_req,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CH_W-1:0]   req_chan,
  input  logic [CNT_W-1:0]  req_len,
  output logic              req_err,
  output logic [NUM_RN-1:0] rn_resetn,
  output logic [NUM_SN-1:0] sn_resetn,
  output logic              rstn,
  output logic              seq_done
);

  typedef logic [CH_W-1:0] ch_t;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STG_LOAD  = (STAGGER > 0) ? CNT_W'(STAGGER - 1) : '0;
  localparam chi_rst_idx_t     LAST_IDX  = chi_rst_idx_t'(NCH - 1);
  localparam chi_rst_idx_t     ALL_IDX   = chi_rst_idx_t'(NCH);
  localparam logic [CH_W:0]    NCH_C     = (CH_W + 1)'(NCH);

  chi_rst_state_e   state_q, state_d;
  logic [NCH-1:0]   resetn_q, resetn_d;
  chi_rst_idx_t     idx_q, idx_d;
  logic             armed_q, armed_d;
  ch_t              warm_ch_q, warm_ch_d;
  logic             run_q, run_d;
  logic             err_q, err_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt_value_unused;
  logic             cnt_zero;

  logic             rel_fire;
  chi_rst_idx_t     rel_ch;
  logic             chan_ok;
  logic [CNT_W-1:0] warm_load;

  chi_reset_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .value    (cnt_value_unused),
    .zero     (cnt_zero)
  );

  assign chan_ok   = ({1'b0, req_chan} < NCH_C);
  // A zero length still gives the channel one cycle of reset.
  assign warm_load = (req_len == '0) ? '0 : req_len - CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    resetn_d     = resetn_q;
    idx_d        = idx_q;
    armed_d      = armed_q;
    warm_ch_d    = warm_ch_q;
    run_d        = run_q;
    err_d        = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    rel_fire     = 1'b0;
    rel_ch       = '0;
    req_ready    = 1'b0;

    if (cold_req) begin
      state_d  = HOLD;
      resetn_d = '0;
      idx_d    = '0;
      armed_d  = 1'b0;
      run_d    = 1'b0;
      cnt_load = 1'b1;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (!armed_q) begin
            armed_d      = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = HOLD_LOAD;
          end else if (cnt_zero) begin
            rel_fire = 1'b1;
          end
        end
        RELEASE: begin
          if (cnt_zero) begin
            if (idx_q == ALL_IDX) begin
              state_d = RUN;
              run_d   = 1'b1;
            end else begin
              rel_fire = 1'b1;
              rel_ch   = idx_q;
            end
          end
        end
        RUN: begin
          req_ready = 1'b1;
          if (req_valid) begin
            if (chan_ok) begin
              state_d      = WARM;
              warm_ch_d    = req_chan;
              cnt_load     = 1'b1;
              cnt_load_val = warm_load;
              for (int i = 0; i < NCH; i++) begin
                if (ch_t'(i) == req_chan) resetn_d[i] = 1'b0;
              end
            end else begin
              err_d = 1'b1;
            end
          end
        end
        WARM: begin
          if (cnt_zero) begin
            state_d = RUN;
            for (int i = 0; i < NCH; i++) begin
              if (ch_t'(i) == warm_ch_q) resetn_d[i] = 1'b1;
            end
          end
        end
      endcase

      // The final release waits one edge only, so rstn follows it immediately.
      if (rel_fire) begin
        state_d  = RELEASE;
        cnt_load = 1'b1;
        if (STAGGER == 0) begin
          resetn_d = '1;
          idx_d    = ALL_IDX;
        end else begin
          for (int i = 0; i < NCH; i++) begin
            if (chi_rst_idx_t'(i) == rel_ch) resetn_d[i] = 1'b1;
          end
          idx_d        = rel_ch + chi_rst_idx_t'(1);
          cnt_load_val = (rel_ch == LAST_IDX) ? '0 : STG_LOAD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HOLD;
      resetn_q  <= '0;
      idx_q     <= '0;
      armed_q   <= 1'b0;
      warm_ch_q <= '0;
      run_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      resetn_q  <= resetn_d;
      idx_q     <= idx_d;
      armed_q   <= armed_d;
      warm_ch_q <= warm_ch_d;
      run_q     <= run_d;
      err_q     <= err_d;
    end
  end

  assign rn_resetn = resetn_q[NUM_RN-1:0];
  assign sn_resetn = resetn_q[NCH-1:NUM_RN];
  assign rstn      = run_q;
  assign seq_done  = run_q;
  assign req_err   = err_q;

endmodule

// File: tb/tb_chi_reset_seq.sv
// Directed bench for chi_reset_seq: default build plus a STAGGER=0 build sharing stimulus.
module tb_chi_reset_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cold_req;
  logic        req_valid;
  logic [2:0]  req_chan;
  logic [15:0] req_len;

  logic        req_ready, req_err, rstn, seq_done;
  logic [3:0]  rn_resetn;
  logic [1:0]  sn_resetn;
  logic        ready0, err0, rstn0, done0;
  logic [3:0]  rn0;
  logic [1:0]  sn0;

  always #5 clk = ~clk;

  chi_reset_seq #(.NUM_RN(4), .NUM_SN(2), .HOLD_CYCLES(16), .STAGGER(2), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cold_req  (cold_req),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_chan  (req_chan),
    .req_len   (req_len),
    .req_err   (req_err),
    .rn_resetn (rn_resetn),
    .sn_resetn (sn_resetn),
    .rstn      (rstn),
    .seq_done  (seq_done)
  );

  chi_reset_seq #(.NUM_RN(4), .NUM_SN(2), .HOLD_CYCLES(16), .STAGGER(0), .CNT_W(16)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .cold_req  (cold_req),
    .req_valid (req_valid),
    .req_ready (ready0),
    .req_chan  (req_chan),
    .req_len   (req_len),
    .req_err   (err0),
    .rn_resetn (rn0),
    .sn_resetn (sn0),
    .rstn      (rstn0),
    .seq_done  (done0)
  );

  typedef struct {
    int         edge_n;
    logic [3:0] rn;
    logic [1:0] sn;
    logic       rstn;
    logic [3:0] rn0;
    logic [1:0] sn0;
    logic       rstn0;
  } cold_vec_t;

  typedef struct {
    logic        cold;
    logic        valid;
    logic [2:0]  chan;
    logic [15:0] len;
    logic [3:0]  rn;
    logic [1:0]  sn;
    logic        rstn;
    logic        ready;
    logic        err;
  } run_vec_t;

  cold_vec_t cold_tbl [13];
  run_vec_t  run_tbl  [21];

  int n_cmp = 0;
  int n_bad = 0;
  int e;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int n);
    while (e < n) begin
      step();
      e++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_low(input string tag);
    chk({tag, "_rn"},    32'(rn_resetn), 32'h0);
    chk({tag, "_sn"},    32'(sn_resetn), 32'h0);
    chk({tag, "_rstn"},  32'(rstn),      32'h0);
    chk({tag, "_done"},  32'(seq_done),  32'h0);
    chk({tag, "_err"},   32'(req_err),   32'h0);
    chk({tag, "_rn0"},   32'(rn0),       32'h0);
    chk({tag, "_rstn0"}, 32'(rstn0),     32'h0);
  endtask

  // Caller sets e = -1 just before the first edge with rst and cold_req low.
  task automatic check_cold_seq(input string tag);
    for (int k = 0; k < 13; k++) begin
      run_to(cold_tbl[k].edge_n);
      chk($sformatf("%s_e%0d_rn", tag, e),     32'(rn_resetn), 32'(cold_tbl[k].rn));
      chk($sformatf("%s_e%0d_sn", tag, e),     32'(sn_resetn), 32'(cold_tbl[k].sn));
      chk($sformatf("%s_e%0d_rstn", tag, e),   32'(rstn),      32'(cold_tbl[k].rstn));
      chk($sformatf("%s_e%0d_done", tag, e),   32'(seq_done),  32'(cold_tbl[k].rstn));
      chk($sformatf("%s_e%0d_ready", tag, e),  32'(req_ready), 32'(cold_tbl[k].rstn));
      chk($sformatf("%s_e%0d_err", tag, e),    32'(req_err),   32'h0);
      chk($sformatf("%s_e%0d_rn0", tag, e),    32'(rn0),       32'(cold_tbl[k].rn0));
      chk($sformatf("%s_e%0d_sn0", tag, e),    32'(sn0),       32'(cold_tbl[k].sn0));
      chk($sformatf("%s_e%0d_rstn0", tag, e),  32'(rstn0),     32'(cold_tbl[k].rstn0));
      chk($sformatf("%s_e%0d_done0", tag, e),  32'(done0),     32'(cold_tbl[k].rstn0));
      chk($sformatf("%s_e%0d_ready0", tag, e), 32'(ready0),    32'(cold_tbl[k].rstn0));
      chk($sformatf("%s_e%0d_err0", tag, e),   32'(err0),      32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //                 edge  rn     sn    rstn  rn0    sn0   rstn0
    cold_tbl[0]  = '{  0, 4'h0, 2'h0, 1'b0, 4'h0, 2'h0, 1'b0};
    cold_tbl[1]  = '{ 15, 4'h0, 2'h0, 1'b0, 4'h0, 2'h0, 1'b0};
    cold_tbl[2]  = '{ 16, 4'h1, 2'h0, 1'b0, 4'hF, 2'h3, 1'b0};
    cold_tbl[3]  = '{ 17, 4'h1, 2'h0, 1'b0, 4'hF, 2'h3, 1'b1};
    cold_tbl[4]  = '{ 18, 4'h3, 2'h0, 1'b0, 4'hF, 2'h3, 1'b1};
    cold_tbl[5]  = '{ 19, 4'h3, 2'h0, 1'b0, 4'hF, 2'h3, 1'b1};
    cold_tbl[6]  = '{ 20, 4'h7, 2'h0, 1'b0, 4'hF, 2'h3, 1'b1};
    cold_tbl[7]  = '{ 22, 4'hF, 2'h0, 1'b0, 4'hF, 2'h3, 1'b1};
    cold_tbl[8]  = '{ 23, 4'hF, 2'h0, 1'b0, 4'hF, 2'h3, 1'b1};
    cold_tbl[9]  = '{ 24, 4'hF, 2'h1, 1'b0, 4'hF, 2'h3, 1'b1};
    cold_tbl[10] = '{ 26, 4'hF, 2'h3, 1'b0, 4'hF, 2'h3, 1'b1};
    cold_tbl[11] = '{ 27, 4'hF, 2'h3, 1'b1, 4'hF, 2'h3, 1'b1};
    cold_tbl[12] = '{ 28, 4'hF, 2'h3, 1'b1, 4'hF, 2'h3, 1'b1};

    //                cold  valid chan  len     rn    sn    rstn  ready err
    run_tbl[0]  = '{1'b0, 1'b0, 3'd0, 16'd0, 4'hF, 2'h3, 1'b1, 1'b1, 1'b0};
    run_tbl[1]  = '{1'b0, 1'b1, 3'd4, 16'd5, 4'hF, 2'h2, 1'b1, 1'b0, 1'b0};
    run_tbl[2]  = '{1'b0, 1'b0, 3'd0, 16'd0, 4'hF, 2'h2, 1'b1, 1'b0, 1'b0};
    run_tbl[3]  = '{1'b0, 1'b0, 3'd0, 16'd0, 4'hF, 2'h2, 1'b1, 1'b0, 1'b0};
    run_tbl[4]  = '{1'b0, 1'b0, 3'd0, 16'd0, 4'hF, 2'h2, 1'b1, 1'b0, 1'b0};
    run_tbl[5]  = '{1'b0, 1'b0, 3'd0, 16'd0, 4'hF, 2'h2, 1'b1, 1'b0, 1'b0};
    run_tbl[6]  = '{1'b0, 1'b0, 3'd0, 16'd0, 4'hF, 2'h3, 1'b1, 1'b1, 1'b0};
    run_tbl[7]  = '{1'b0, 1'b1, 3'd4, 16'd0, 4'hF, 2'h2, 1'b1, 1'b0, 1'b0};
    run_tbl[8]  = '{1'b0, 1'b0, 3'd0, 16'd0, 4'hF, 2'h3, 1'b1, 1'b1, 1'b0};
    run_tbl[9]  = '{1'b0, 1'b1, 3'd7, 16'd3, 4'hF, 2'h3, 1'b1, 1'b1, 1'b1};
    run_tbl[10] = '{1'b0, 1'b0, 3'd0, 16'd0, 4'hF, 2'h3, 1'b1, 1'b1, 1'b0};
    run_tbl[11] = '{1'b0, 1'b1, 3'd6, 16'd0, 4'hF, 2'h3, 1'b1, 1'b1, 1'b1};
    run_tbl[12] = '{1'b0, 1'b1, 3'd5, 16'd1, 4'hF, 2'h1, 1'b1, 1'b0, 1'b0};
    run_tbl[13] = '{1'b0, 1'b0, 3'd0, 16'd0, 4'hF, 2'h3, 1'b1, 1'b1, 1'b0};
    run_tbl[14] = '{1'b0, 1'b1, 3'd1, 16'd2, 4'hD, 2'h3, 1'b1, 1'b0, 1'b0};
    run_tbl[15] = '{1'b0, 1'b1, 3'd1, 16'd2, 4'hD, 2'h3, 1'b1, 1'b0, 1'b0};
    run_tbl[16] = '{1'b0, 1'b1, 3'd1, 16'd2, 4'hF, 2'h3, 1'b1, 1'b1, 1'b0};
    run_tbl[17] = '{1'b0, 1'b1, 3'd1, 16'd2, 4'hD, 2'h3, 1'b1, 1'b0, 1'b0};
    run_tbl[18] = '{1'b0, 1'b0, 3'd0, 16'd0, 4'hD, 2'h3, 1'b1, 1'b0, 1'b0};
    run_tbl[19] = '{1'b0, 1'b0, 3'd0, 16'd0, 4'hF, 2'h3, 1'b1, 1'b1, 1'b0};
    run_tbl[20] = '{1'b1, 1'b1, 3'd0, 16'd4, 4'h0, 2'h0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; cold_req = 1'b0; req_valid = 1'b0; req_chan = '0; req_len = '0;
    step();
    step();
    chk_all_low("reset");
    chk("reset_ready", 32'(req_ready), 32'h0);

    rst = 1'b0;
    e = -1;
    check_cold_seq("cold");

    // RUN-phase vectors: inputs held across the edge, outputs checked after it.
    for (int k = 0; k < 21; k++) begin
      cold_req  = run_tbl[k].cold;
      req_valid = run_tbl[k].valid;
      req_chan  = run_tbl[k].chan;
      req_len   = run_tbl[k].len;
      step();
      chk($sformatf("run%0d_rn", k),    32'(rn_resetn), 32'(run_tbl[k].rn));
      chk($sformatf("run%0d_sn", k),    32'(sn_resetn), 32'(run_tbl[k].sn));
      chk($sformatf("run%0d_rstn", k),  32'(rstn),      32'(run_tbl[k].rstn));
      chk($sformatf("run%0d_done", k),  32'(seq_done),  32'(run_tbl[k].rstn));
      chk($sformatf("run%0d_ready", k), 32'(req_ready), 32'(run_tbl[k].ready));
      chk($sformatf("run%0d_err", k),   32'(req_err),   32'(run_tbl[k].err));
    end
    cold_req = 1'b0; req_valid = 1'b0; req_chan = '0; req_len = '0;
    e = -1;
    check_cold_seq("prio_replay");

    // req_ready is combinational on cold_req while in RUN.
    cold_req = 1'b1;
    #1;
    chk("ready_cold_masked", 32'(req_ready), 32'h0);
    cold_req = 1'b0;
    #1;
    chk("ready_cold_clear", 32'(req_ready), 32'h1);

    // Abort a len-10 warm reset during its second cycle.
    req_valid = 1'b1; req_chan = 3'd4; req_len = 16'd10;
    step();
    req_valid = 1'b0;
    chk("abort_acc_sn", 32'(sn_resetn), 32'h2);
    chk("abort_acc_ready", 32'(req_ready), 32'h0);
    step();
    chk("abort_c2_sn", 32'(sn_resetn), 32'h2);
    chk("abort_c2_rstn", 32'(rstn), 32'h1);
    cold_req = 1'b1;
    step();
    chk_all_low("abort");
    chk("abort_ready", 32'(req_ready), 32'h0);
    cold_req = 1'b0;
    e = -1;
    check_cold_seq("abort_replay");

    // Synchronous reset in the middle of a cold sequence.
    rst = 1'b1;
    step();
    rst = 1'b0;
    e = -1;
    run_to(19);
    chk("mid_e19_rn", 32'(rn_resetn), 32'h3);
    chk("mid_e19_rn0", 32'(rn0), 32'hF);
    rst = 1'b1;
    step();
    chk_all_low("mid_rst");
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    rst = 1'b0;
    e = -1;
    check_cold_seq("mid_replay");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
